sdram_arbit: RTL and testbench

//  Shares the single SDRAM command/data bus among the init, auto-refresh, write and read sub-controllers.
//  - Grants exactly one requester at a time.
//  - Drives that requester's cmd/ba/addr onto the pins.
//  - Owns the DQ output enable.
//  - Sits between the sub-controllers and the SDRAM pads, below the FIFO-style controller top.

---
 rtl/sdram_arbit_pkg.sv | 25 ++
 rtl/sdram_arbit.sv | 134 +++++++++++++
 tb/tb_sdram_arbit.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/sdram_arbit_pkg.sv
// Shared definitions for the SDRAM controller slice.
// - State encoding of the bus arbiter.
// - SDRAM command constants {cs_n, ras_n, cas_n, we_n}.
// These are also used by the init, auto-refresh, write and read sub-controllers.
package sdram_arbit_pkg;

  // Arbiter states. Codes 5..7 are unused and recover to ST_IDLE.
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ARBIT = 3'd1,
    ST_AREF  = 3'd2,
    ST_WRITE = 3'd3,
    ST_READ  = 3'd4
  } state_t;

  // SDRAM commands as {cs_n, ras_n, cas_n, we_n}.
  localparam logic [3:0] CMD_NOP      = 4'b0111;
  localparam logic [3:0] CMD_ACTIVE   = 4'b0011;
  localparam logic [3:0] CMD_READ     = 4'b0101;
  localparam logic [3:0] CMD_WRITE    = 4'b0100;
  localparam logic [3:0] CMD_B_STOP   = 4'b0110;
  localparam logic [3:0] CMD_P_CHARGE = 4'b0010;
  localparam logic [3:0] CMD_A_REF    = 4'b0001;

endpackage

// File: rtl/sdram_arbit.sv
// sdram_arbit: shares the single SDRAM command/data bus among the init,
// auto-refresh, write and read sub-controllers.
//
// Behaviour summary:
// - Exactly one requester owns the pins at a time.
// - Its cmd/ba/addr are muxed combinationally from the registered state.
// - DQ is driven only while the write module owns the bus.
//
// Ports:
//   sys_clk, sys_rst_n          clock, asynchronous active-low reset
//   init_end, init_*            init done level, init-phase cmd/ba/addr
//   aref_req/aref_end, aref_*   refresh request level, done pulse, cmd/ba/addr
//   wr_req/wr_end, wr_*         write request level, done pulse, cmd/ba/addr,
//                               wr_sdram_en / wr_sdram_data DQ drive
//   rd_req/rd_end, rd_*         read request level, done pulse, cmd/ba/addr
//   aref_en, wr_en, rd_en       registered grants
//   sdram_*                     pad-side command, address and DQ drive
//   state_dbg                   current arbiter state, for observation
//
// Handshake: a sub-controller holds *_req as a level until it sees its *_en
// grant. It then owns the pins until it pulses *_end for one cycle. The grant
// drops on the edge that samples *_end. The arbiter always spends at least
// one NOP cycle in ARBIT before issuing the next grant.
module sdram_arbit
  import sdram_arbit_pkg::*;
#(
  parameter int         DATA_W = 32,
  parameter int         ADDR_W = 11,
  parameter int         BA_W   = 2,
  parameter logic [3:0] NOP    = CMD_NOP
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  input  logic              init_end,
  input  logic [3:0]        init_cmd,
  input  logic [BA_W-1:0]   init_ba,
  input  logic [ADDR_W-1:0] init_addr,
  input  logic              aref_req,
  input  logic              aref_end,
  input  logic [3:0]        aref_cmd,
  input  logic [BA_W-1:0]   aref_ba,
  input  logic [ADDR_W-1:0] aref_addr,
  input  logic              wr_req,
  input  logic              wr_end,
  input  logic [3:0]        wr_cmd,
  input  logic [BA_W-1:0]   wr_ba,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic              wr_sdram_en,
  input  logic [DATA_W-1:0] wr_sdram_data,
  input  logic              rd_req,
  input  logic              rd_end,
  input  logic [3:0]        rd_cmd,
  input  logic [BA_W-1:0]   rd_ba,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              aref_en,
  output logic              wr_en,
  output logic              rd_en,
  output logic              sdram_cke,
  output logic              sdram_cs_n,
  output logic              sdram_ras_n,
  output logic              sdram_cas_n,
  output logic              sdram_we_n,
  output logic [BA_W-1:0]   sdram_ba,
  output logic [ADDR_W-1:0] sdram_addr,
  output logic [DATA_W-1:0] sdram_dq_out,
  output logic              sdram_dq_oe,
  output state_t            state_dbg
);

  state_t      state, next_state;
  logic        last_wr;   // 1: the last completed burst was a write
  logic [3:0]  cmd;

  // State register. The grants are registered from next_state, so each
  // grant rises on the same edge that enters its state.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state   <= ST_IDLE;
      aref_en <= 1'b0;
      wr_en   <= 1'b0;
      rd_en   <= 1'b0;
      last_wr <= 1'b0;
    end else begin
      state   <= next_state;
      aref_en <= (next_state == ST_AREF);
      wr_en   <= (next_state == ST_WRITE);
      rd_en   <= (next_state == ST_READ);
      if (state == ST_WRITE && wr_end)
        last_wr <= 1'b1;
      else if (state == ST_READ && rd_end)
        last_wr <= 1'b0;
    end
  end

  // Next-state logic. Refresh has priority. A write/read tie alternates on
  // last_wr. An *_end pulse is only honoured in its owning state.
  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE:  if (init_end) next_state = ST_ARBIT;
      ST_ARBIT: begin
        if (aref_req)              next_state = ST_AREF;
        else if (wr_req && rd_req) next_state = last_wr ? ST_READ : ST_WRITE;
        else if (wr_req)           next_state = ST_WRITE;
        else if (rd_req)           next_state = ST_READ;
      end
      ST_AREF:  if (aref_end) next_state = ST_ARBIT;
      ST_WRITE: if (wr_end)   next_state = ST_ARBIT;
      ST_READ:  if (rd_end)   next_state = ST_ARBIT;
      default:  next_state = ST_IDLE;
    endcase
  end

  // Pin mux, combinational from the registered state.
  always_comb begin
    cmd        = NOP;
    sdram_ba   = '1;
    sdram_addr = '1;
    case (state)
      ST_IDLE:  begin cmd = init_cmd; sdram_ba = init_ba; sdram_addr = init_addr; end
      ST_AREF:  begin cmd = aref_cmd; sdram_ba = aref_ba; sdram_addr = aref_addr; end
      ST_WRITE: begin cmd = wr_cmd;   sdram_ba = wr_ba;   sdram_addr = wr_addr;   end
      ST_READ:  begin cmd = rd_cmd;   sdram_ba = rd_ba;   sdram_addr = rd_addr;   end
      default:  ;
    endcase
  end

  assign {sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n} = cmd;
  assign sdram_cke    = 1'b1;
  assign sdram_dq_oe  = (state == ST_WRITE) && wr_sdram_en;
  assign sdram_dq_out = sdram_dq_oe ? wr_sdram_data : '0;
  assign state_dbg    = state;

endmodule

// File: tb/tb_sdram_arbit.sv
module tb_sdram_arbit;
  import sdram_arbit_pkg::*;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 11;
  localparam int BA_W   = 2;

  logic              sys_clk, sys_rst_n;
  logic              init_end, aref_req, aref_end, wr_req, wr_end, rd_req, rd_end;
  logic [3:0]        init_cmd, aref_cmd, wr_cmd, rd_cmd;
  logic [BA_W-1:0]   init_ba, aref_ba, wr_ba, rd_ba;
  logic [ADDR_W-1:0] init_addr, aref_addr, wr_addr, rd_addr;
  logic              wr_sdram_en;
  logic [DATA_W-1:0] wr_sdram_data;
  logic              aref_en, wr_en, rd_en, sdram_cke;
  logic              sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n;
  logic [BA_W-1:0]   sdram_ba;
  logic [ADDR_W-1:0] sdram_addr;
  logic [DATA_W-1:0] sdram_dq_out;
  logic              sdram_dq_oe;
  state_t            state_dbg;

  int checks = 0;
  int errors = 0;

  wire [3:0] pin_cmd = {sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n};
  wire [2:0] grants  = {aref_en, wr_en, rd_en};

  sdram_arbit #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .BA_W(BA_W)) dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n),
    .init_end(init_end), .init_cmd(init_cmd), .init_ba(init_ba), .init_addr(init_addr),
    .aref_req(aref_req), .aref_end(aref_end), .aref_cmd(aref_cmd), .aref_ba(aref_ba),
    .aref_addr(aref_addr),
    .wr_req(wr_req), .wr_end(wr_end), .wr_cmd(wr_cmd), .wr_ba(wr_ba), .wr_addr(wr_addr),
    .wr_sdram_en(wr_sdram_en), .wr_sdram_data(wr_sdram_data),
    .rd_req(rd_req), .rd_end(rd_end), .rd_cmd(rd_cmd), .rd_ba(rd_ba), .rd_addr(rd_addr),
    .aref_en(aref_en), .wr_en(wr_en), .rd_en(rd_en), .sdram_cke(sdram_cke),
    .sdram_cs_n(sdram_cs_n), .sdram_ras_n(sdram_ras_n), .sdram_cas_n(sdram_cas_n),
    .sdram_we_n(sdram_we_n), .sdram_ba(sdram_ba), .sdram_addr(sdram_addr),
    .sdram_dq_out(sdram_dq_out), .sdram_dq_oe(sdram_dq_oe), .state_dbg(state_dbg)
  );

  // Clock / reset
  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  // Advance one clock; inputs change and outputs are sampled 1 ns after the edge.
  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge sys_clk);
      #1;
    end
  endtask

  task automatic test_reset();
    sys_rst_n = 1'b0;
    init_end = 1'b0; aref_req = 1'b0; aref_end = 1'b0;
    wr_req = 1'b0; wr_end = 1'b0; rd_req = 1'b0; rd_end = 1'b0;
    init_cmd = 4'b0010;  init_ba = 2'b01; init_addr = 11'h400;
    aref_cmd = CMD_A_REF; aref_ba = 2'b00; aref_addr = 11'h011;
    wr_cmd = CMD_WRITE;  wr_ba = 2'b10;   wr_addr = 11'h155;
    rd_cmd = CMD_READ;   rd_ba = 2'b11;   rd_addr = 11'h2AA;
    wr_sdram_en = 1'b0;  wr_sdram_data = 32'h0;
    tick(3);
    sys_rst_n = 1'b1;
    tick(20);
    checks++; if (state_dbg !== ST_IDLE) begin errors++; $display("FAIL reset_state: got %0d expected %0d", state_dbg, ST_IDLE); end
    checks++; if (pin_cmd !== 4'b0010) begin errors++; $display("FAIL reset_cmd: got %b expected 0010", pin_cmd); end
    checks++; if (sdram_ba !== 2'b01 || sdram_addr !== 11'h400) begin errors++; $display("FAIL reset_ba_addr: got %b/%h expected 01/400", sdram_ba, sdram_addr); end
    checks++; if (grants !== 3'b000) begin errors++; $display("FAIL reset_grants: got %b expected 000", grants); end
    checks++; if (sdram_cke !== 1'b1) begin errors++; $display("FAIL reset_cke: got %b expected 1", sdram_cke); end
    checks++; if (sdram_dq_oe !== 1'b0 || sdram_dq_out !== 32'h0) begin errors++; $display("FAIL reset_dq: got oe=%b out=%h expected 0/0", sdram_dq_oe, sdram_dq_out); end
  endtask

  task automatic test_init_aref();
    init_end = 1'b1; aref_req = 1'b1; wr_req = 1'b1;
    tick();   // IDLE -> ARBIT
    checks++; if (state_dbg !== ST_ARBIT || grants !== 3'b000) begin errors++; $display("FAIL arbit_after_init: got state=%0d grants=%b expected 1/000", state_dbg, grants); end
    checks++; if (pin_cmd !== 4'b0111 || sdram_ba !== 2'b11 || sdram_addr !== 11'h7FF) begin errors++; $display("FAIL arbit_nop: got %b/%b/%h expected 0111/11/7ff", pin_cmd, sdram_ba, sdram_addr); end
    tick();   // ARBIT -> AREF (refresh beats write)
    checks++; if (grants !== 3'b100) begin errors++; $display("FAIL aref_grant: got %b expected 100", grants); end
    checks++; if (pin_cmd !== CMD_A_REF || sdram_addr !== 11'h011) begin errors++; $display("FAIL aref_pins: got %b/%h expected 0001/011", pin_cmd, sdram_addr); end
    init_end = 1'b0;   // must have no effect after IDLE
    tick(3);
    checks++; if (grants !== 3'b100) begin errors++; $display("FAIL aref_hold: got %b expected 100", grants); end
    aref_end = 1'b1; aref_req = 1'b0;
    tick();
    aref_end = 1'b0;
    checks++; if (grants !== 3'b000 || pin_cmd !== 4'b0111) begin errors++; $display("FAIL aref_release: got grants=%b cmd=%b expected 000/0111", grants, pin_cmd); end
    tick();
    checks++; if (grants !== 3'b010) begin errors++; $display("FAIL wr_after_aref: got %b expected 010", grants); end
  endtask

  task automatic test_dq();
    wr_sdram_en = 1'b1; wr_sdram_data = 32'hA5A5_5A5A;
    #1;
    checks++; if (sdram_dq_oe !== 1'b1 || sdram_dq_out !== 32'hA5A5_5A5A) begin errors++; $display("FAIL dq_write: got oe=%b out=%h expected 1/a5a55a5a", sdram_dq_oe, sdram_dq_out); end
    checks++; if (pin_cmd !== CMD_WRITE || sdram_ba !== 2'b10 || sdram_addr !== 11'h155) begin errors++; $display("FAIL wr_pins: got %b/%b/%h expected 0100/10/155", pin_cmd, sdram_ba, sdram_addr); end
    wr_sdram_en = 1'b0;
    #1;
    checks++; if (sdram_dq_oe !== 1'b0 || sdram_dq_out !== 32'h0) begin errors++; $display("FAIL dq_idle_in_write: got oe=%b out=%h expected 0/0", sdram_dq_oe, sdram_dq_out); end
  endtask

  // Currently in WRITE (burst 1); alternate WRITE -> READ -> WRITE.
  task automatic test_alternate();
    rd_req = 1'b1;
    tick(2);
    checks++; if (grants !== 3'b010) begin errors++; $display("FAIL wr_wait_rd: got %b expected 010", grants); end
    wr_end = 1'b1;
    tick();
    wr_end = 1'b0;
    checks++; if (grants !== 3'b000 || pin_cmd !== 4'b0111) begin errors++; $display("FAIL gap1: got grants=%b cmd=%b expected 000/0111", grants, pin_cmd); end
    tick();
    checks++; if (grants !== 3'b001) begin errors++; $display("FAIL second_grant_read: got %b expected 001", grants); end
    checks++; if (pin_cmd !== CMD_READ || sdram_addr !== 11'h2AA) begin errors++; $display("FAIL rd_pins: got %b/%h expected 0101/2aa", pin_cmd, sdram_addr); end
    wr_sdram_en = 1'b1; wr_sdram_data = 32'hDEAD_BEEF;
    #1;
    checks++; if (sdram_dq_oe !== 1'b0 || sdram_dq_out !== 32'h0) begin errors++; $display("FAIL dq_in_read: got oe=%b out=%h expected 0/0", sdram_dq_oe, sdram_dq_out); end
    wr_sdram_en = 1'b0;
    wr_end = 1'b1;     // foreign end pulse: ignored
    tick();
    wr_end = 1'b0;
    checks++; if (grants !== 3'b001) begin errors++; $display("FAIL foreign_end: got %b expected 001", grants); end
    rd_end = 1'b1;
    tick();
    rd_end = 1'b0;
    checks++; if (grants !== 3'b000 || pin_cmd !== 4'b0111) begin errors++; $display("FAIL gap2: got grants=%b cmd=%b expected 000/0111", grants, pin_cmd); end
    tick();
    checks++; if (grants !== 3'b010) begin errors++; $display("FAIL third_grant_write: got %b expected 010", grants); end
  endtask

  // Refresh raised during a read waits for rd_end.
  task automatic test_aref_mid_read();
    wr_end = 1'b1; wr_req = 1'b0;
    tick();
    wr_end = 1'b0;
    tick();
    checks++; if (grants !== 3'b001) begin errors++; $display("FAIL read_only_grant: got %b expected 001", grants); end
    aref_req = 1'b1;
    tick(3);
    checks++; if (grants !== 3'b001) begin errors++; $display("FAIL no_preempt: got %b expected 001", grants); end
    rd_end = 1'b1; rd_req = 1'b0;
    tick();
    rd_end = 1'b0;
    checks++; if (grants !== 3'b000) begin errors++; $display("FAIL rd_release: got %b expected 000", grants); end
    tick();
    checks++; if (grants !== 3'b100) begin errors++; $display("FAIL aref_after_read: got %b expected 100", grants); end
    aref_end = 1'b1; aref_req = 1'b0;
    tick();
    aref_end = 1'b0;
    tick(2);
    checks++; if (state_dbg !== ST_ARBIT || grants !== 3'b000) begin errors++; $display("FAIL arbit_idle: got state=%0d grants=%b expected 1/000", state_dbg, grants); end
  endtask

  task automatic test_reset_mid_burst();
    wr_req = 1'b1; init_end = 1'b1;
    tick();
    wr_sdram_en = 1'b1; wr_sdram_data = 32'h1234_5678;
    #1;
    checks++; if (wr_en !== 1'b1 || sdram_dq_oe !== 1'b1) begin errors++; $display("FAIL pre_reset_write: got wr_en=%b oe=%b expected 1/1", wr_en, sdram_dq_oe); end
    #2;
    sys_rst_n = 1'b0;   // between edges
    #1;
    checks++; if (wr_en !== 1'b0 || sdram_dq_oe !== 1'b0 || sdram_dq_out !== 32'h0) begin errors++; $display("FAIL async_reset: got wr_en=%b oe=%b out=%h expected 0/0/0", wr_en, sdram_dq_oe, sdram_dq_out); end
    checks++; if (state_dbg !== ST_IDLE || pin_cmd !== 4'b0010) begin errors++; $display("FAIL reset_pins: got state=%0d cmd=%b expected 0/0010", state_dbg, pin_cmd); end
    tick(2);
    sys_rst_n = 1'b1;
    tick();
    checks++; if (state_dbg !== ST_ARBIT || wr_en !== 1'b0) begin errors++; $display("FAIL post_reset_arbit: got state=%0d wr_en=%b expected 1/0", state_dbg, wr_en); end
    tick();
    checks++; if (wr_en !== 1'b1 || state_dbg !== ST_WRITE) begin errors++; $display("FAIL post_reset_write: got state=%0d wr_en=%b expected 3/1", state_dbg, wr_en); end
    wr_sdram_en = 1'b0; wr_req = 1'b0;
  endtask

  initial begin
    test_reset();
    test_init_aref();
    test_dq();
    test_alternate();
    test_aref_mid_read();
    test_reset_mid_burst();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
